// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment capture block: segment patterns,
// frame FSM states and the pattern-to-BCD decoder.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {COLLECT, COMPUTE, PUBLISH} frame_state_t;

    // Returns {valid, blank, digit[3:0]}; a dark digit reads as 0 with blank set.
    function automatic logic [5:0] seg_to_bcd(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            SEG_0:     r = 6'b10_0000;
            SEG_1:     r = 6'b10_0001;
            SEG_2:     r = 6'b10_0010;
            SEG_3:     r = 6'b10_0011;
            SEG_4:     r = 6'b10_0100;
            SEG_5:     r = 6'b10_0101;
            SEG_6:     r = 6'b10_0110;
            SEG_7:     r = 6'b10_0111;
            SEG_8:     r = 6'b10_1000;
            SEG_9:     r = 6'b10_1001;
            SEG_BLANK: r = 6'b11_0000;
            default:   r = 6'b00_0000;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] times10(input logic [9:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Scanned seven-segment bus plus the recovered-value outputs of the capture block.
interface sevenseg_capture_if
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 3
);
    logic [6:0]            seg_i;
    logic [NUM_DIGITS-1:0] dig_i;
    logic [9:0]            value_o;
    logic                  value_valid_o;
    logic                  err_o;
    logic [NUM_DIGITS-1:0] blank_o;

    modport master (
        output seg_i, dig_i,
        input  value_o, value_valid_o, err_o, blank_o
    );

    modport slave (
        input  seg_i, dig_i,
        output value_o, value_valid_o, err_o, blank_o
    );
endinterface

// File: rtl/seg_qualify.sv
// Synchronises the raw display bus and emits one capture strobe per digit
// strobe that has held a single-hot, unchanging pattern long enough.
module seg_qualify
    import sevenseg_pkg::*;
#(
    parameter  int NUM_DIGITS     = 3,
    parameter  int SETTLE_CYCLES  = 4,
    parameter  int SEG_ACTIVE_LOW = 0,
    parameter  int DIG_ACTIVE_LOW = 0,
    localparam int IDXW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_raw,
    input  logic [NUM_DIGITS-1:0] dig_raw,
    output logic                  cap,
    output logic [IDXW-1:0]       cap_idx,
    output logic [6:0]            cap_seg
);
    localparam int W = 7 + NUM_DIGITS;

    logic [W-1:0]          sync1, sync2, prev, cur;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] dig_n;
    logic [7:0]            count;
    logic                  stable;
    logic [IDXW-1:0]       idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {seg_raw, dig_raw};
            sync2 <= sync1;
        end
    end

    always_comb begin
        seg_n  = (SEG_ACTIVE_LOW != 0) ? ~sync2[W-1:NUM_DIGITS] : sync2[W-1:NUM_DIGITS];
        dig_n  = (DIG_ACTIVE_LOW != 0) ? ~sync2[NUM_DIGITS-1:0] : sync2[NUM_DIGITS-1:0];
        cur    = {seg_n, dig_n};
        stable = (cur == prev) && $onehot(dig_n);
        idx    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_n[k]) idx = IDXW'(k);
        end
    end

    // Counter saturates at SETTLE_CYCLES so the capture fires once per stable window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            count   <= '0;
            cap     <= 1'b0;
            cap_idx <= '0;
            cap_seg <= '0;
        end else begin
            prev <= cur;
            if (!stable) begin
                count <= '0;
            end else if (count != 8'(SETTLE_CYCLES)) begin
                count <= count + 8'd1;
            end
            cap     <= stable && (count == 8'(SETTLE_CYCLES - 1));
            cap_idx <= idx;
            cap_seg <= seg_n;
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers the decimal value shown on a scanned seven-segment display:
// collects one capture per digit slot, then computes and publishes the frame.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input logic               clk,
    input logic               rst_n,
    sevenseg_capture_if.slave bus
);
    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  cap;
    logic [IDXW-1:0]       cap_idx;
    logic [6:0]            cap_seg;

    frame_state_t          state;
    logic [3:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] seen, slot_err, slot_blank;
    logic                  pend_v;
    logic [IDXW-1:0]       pend_idx;
    logic [6:0]            pend_seg;

    logic                  wr_en;
    logic [IDXW-1:0]       wr_idx;
    logic [6:0]            wr_seg;
    logic [5:0]            wr_bcd;
    logic [NUM_DIGITS-1:0] wr_mask;
    logic [9:0]            sum;

    logic [9:0]            value_q;
    logic                  valid_q, err_q;
    logic [NUM_DIGITS-1:0] blank_q;

    seg_qualify #(
        .NUM_DIGITS    (NUM_DIGITS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW(DIG_ACTIVE_LOW)
    ) u_qualify (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_raw(bus.seg_i),
        .dig_raw(bus.dig_i),
        .cap    (cap),
        .cap_idx(cap_idx),
        .cap_seg(cap_seg)
    );

    // Captures seen during COMPUTE are parked and replayed in PUBLISH, after the clear.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = cap_idx;
        wr_seg = cap_seg;
        case (state)
            COLLECT: wr_en = cap;
            PUBLISH: begin
                wr_en = pend_v | cap;
                if (pend_v) begin
                    wr_idx = pend_idx;
                    wr_seg = pend_seg;
                end
            end
            default: wr_en = 1'b0;
        endcase
        wr_bcd  = seg_to_bcd(wr_seg);
        wr_mask = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (wr_en && (wr_idx == IDXW'(k))) wr_mask[k] = 1'b1;
        end
    end

    // Horner evaluation keeps the arithmetic to shifts and adds.
    always_comb begin
        sum = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            sum = times10(sum) + {6'd0, digit[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            seen       <= '0;
            slot_err   <= '0;
            slot_blank <= '0;
            pend_v     <= 1'b0;
            pend_idx   <= '0;
            pend_seg   <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            blank_q    <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) digit[k] <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (&(seen | wr_mask)) state <= COMPUTE;
                end
                COMPUTE: begin
                    if (|slot_err) begin
                        err_q <= 1'b1;
                    end else begin
                        value_q <= sum;
                        blank_q <= slot_blank;
                        valid_q <= 1'b1;
                    end
                    if (cap) begin
                        pend_v   <= 1'b1;
                        pend_idx <= cap_idx;
                        pend_seg <= cap_seg;
                    end
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    seen       <= '0;
                    slot_err   <= '0;
                    slot_blank <= '0;
                    pend_v     <= 1'b0;
                    state      <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (wr_mask[k]) begin
                    digit[k]      <= wr_bcd[3:0];
                    slot_blank[k] <= wr_bcd[4];
                    slot_err[k]   <= ~wr_bcd[5];
                    seen[k]       <= 1'b1;
                end
            end
        end
    end

    assign bus.value_o       = value_q;
    assign bus.value_valid_o = valid_q;
    assign bus.err_o         = err_q;
    assign bus.blank_o       = blank_q;

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart to the team's multiplexed seven-segment driver. Watches a scanned seven-segment bus (segment lines plus one-hot digit strobes) and recovers the displayed decimal value as binary. It is used as a loop-back checker and as a capture block that lets other logic read a display driven elsewhere. It qualifies each strobe for stability, decodes segment patterns to BCD, assembles a full frame, and publishes a validated binary value.

## Interface
- `NUM_DIGITS`, 3: digits per frame; `dig_i[0]` is the ones digit.
- `SETTLE_CYCLES`, 4: consecutive stable synchronised cycles required before a digit is captured (range 2..255).
- `SEG_ACTIVE_LOW`, 0: 1 means segment lines are inverted at the input.
- `DIG_ACTIVE_LOW`, 0: 1 means digit strobes are inverted at the input.
- `clk` in 1: single system clock (12 MHz on the board).
- `rst_n` in 1: asynchronous, active-low reset.
- `seg_i` in 7: segments, bit order g,f,e,d,c,b,a (bit0 = a); asynchronous to `clk`.
- `dig_i` in NUM_DIGITS: digit strobes, nominally one-hot; asynchronous to `clk`.
- `value_o` out 10: last valid frame value, 0..999.
- `value_valid_o` out 1: one-cycle pulse when `value_o` updates.
- `err_o` out 1: one-cycle pulse when a completed frame contained an undecodable digit.
- `blank_o` out NUM_DIGITS: per-digit blank flags of the last valid frame.

## Operation
- Inputs pass through a 2-FF synchroniser, then polarity is normalised per parameter.
- Qualifier:
  - Compares the current {seg, dig} with the previous cycle's value.
  - A change, zero strobes asserted, or more than one strobe asserted resets the stability counter to 0.
  - Otherwise the counter increments and saturates at SETTLE_CYCLES.
  - A capture fires exactly once, on the cycle the counter reaches SETTLE_CYCLES-1→SETTLE_CYCLES. It does not fire again until the counter is reset.
- Decode, strict patterns (hex, a = bit0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 = blank, treated as digit 0 with its blank flag set.
  - Any other pattern is invalid and sets the slot's err flag.
- Capture writes the slot's digit, blank and err flags and sets its seen bit. Recapturing an already-seen slot overwrites it with the latest data.
- Frame FSM:
  - COLLECT: waits until all seen bits are set.
  - COMPUTE: one cycle. value = Σ digit[k]·10^k using shift-add only (x10 = x<<3 + x<<1), 10-bit result.
  - PUBLISH: one cycle. If no slot err, update `value_o` and `blank_o` and pulse `value_valid_o`. Otherwise pulse `err_o` and hold `value_o` and `blank_o`. Then clear all seen, err and blank scratch state and return to COLLECT.
- Captures arriving during COMPUTE or PUBLISH are applied to the scratch slots only after the clear, so they count toward the next frame.

## Timing
- Reset values:
  - `value_o`=0, `value_valid_o`=0, `err_o`=0, `blank_o`=0.
  - FSM = COLLECT, seen/err flags = 0, stability counter = 0, synchronisers = 0.
- Latency from an input edge to the capture cycle: 2 (sync) + SETTLE_CYCLES cycles.
- Last capture at cycle N gives COMPUTE at N+1, and `value_o`/`value_valid_o` (or `err_o`) at N+2.
- `value_valid_o` and `err_o` are never asserted in the same cycle. Each is a one-cycle pulse per frame.
- Reset mid-frame discards partial slots immediately; no pulse is emitted.
- No frame timeout: a partially scanned frame waits indefinitely.

## Structure
- Package `sevenseg_pkg`:
  - segment pattern constants (SEG_0..SEG_9, SEG_BLANK)
  - FSM state enum {COLLECT, COMPUTE, PUBLISH}
  - a `seg_to_bcd` function returning {valid, blank, digit[3:0]}
- Sub-module `seg_qualify`: synchroniser, polarity normalisation, stability counter, one-hot check, and capture strobe plus digit index. The top module holds the slots, FSM, and arithmetic.

## Test plan
- Scan 255 (dig2=5B, dig1=6D, dig0=6D), each strobe held 8 cycles, SETTLE=4 -> `value_o`=255, exactly one `value_valid_o` pulse per scanned frame, `blank_o`=000.
- Scan 00,00,4F -> `value_o`=3, `blank_o`=110.
- Scan 120 then a frame with dig1=49 -> `err_o` pulse, no valid pulse, `value_o` stays 120.
- Each strobe held only 3 cycles (below SETTLE) -> no capture, no pulses, `value_o` unchanged.
- `dig_i`=011 held 20 cycles while scanning otherwise-valid digits -> that window is ignored; the frame completes only after proper one-hot strobes.
- `rst_n` low after two digits of 099 are captured -> all outputs 0 immediately; the next full scan of 128 yields `value_o`=128 and one valid pulse.
